// File: rtl/time_set_controller.sv
// Time-of-day clock (hh:mm:ss) with hour/minute setting, auto-repeat on btn_inc and a blink strobe.
// tick4/tick1 are single-cycle enables derived from clk_in; no other clocks are used.
module time_set_controller #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned QTR = CLK_HZ / 4;
  localparam int unsigned PW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int unsigned HW  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic [1:0]    quarter;
  logic [HW-1:0] hold, hold_nx;
  logic          mode_q, inc_q;
  logic          tick4, tick1;
  logic          mode_edge, inc_edge;
  logic          rpt, bump, leave_set;

  assign tick4     = (presc == PW'(QTR - 1));
  assign tick1     = tick4 && (quarter == 2'd3);
  assign mode_edge = btn_mode & ~mode_q;
  assign inc_edge  = btn_inc & ~inc_q;
  assign leave_set = (state == SET_MIN) && mode_edge;
  assign mode      = state;

  always_comb begin
    state_nx = state;
    if (mode_edge) begin
      case (state)
        RUN:     state_nx = SET_HR;
        SET_HR:  state_nx = SET_MIN;
        default: state_nx = RUN;
      endcase
    end
  end

  // Hold counter saturates at HOLD_TICKS; repeats fire only on tick4s after it has saturated.
  // Any edge or mode change restarts the hold, so an edge and a repeat never both count.
  always_comb begin
    hold_nx = hold;
    rpt     = 1'b0;
    if (state == RUN || !btn_inc || mode_edge || inc_edge) begin
      hold_nx = '0;
    end else if (tick4) begin
      if (hold == HW'(HOLD_TICKS)) rpt = 1'b1;
      else hold_nx = hold + 1'b1;
    end
  end

  assign bump = (state != RUN) && !mode_edge && (inc_edge || rpt);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state   <= RUN;
      presc   <= '0;
      quarter <= '0;
      hold    <= '0;
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
      blink   <= 1'b0;
    end else begin
      state  <= state_nx;
      hold   <= hold_nx;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;

      if (leave_set) begin
        presc   <= '0;
        quarter <= '0;
      end else if (tick4) begin
        presc   <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (state_nx == RUN)             blink <= 1'b0;
      else if (state != RUN && tick4)  blink <= ~blink;

      if (leave_set) begin
        seconds <= '0;
      end else if (state == RUN && tick1) begin
        if (seconds == 6'd59) begin
          seconds <= '0;
          if (minutes == 6'd59) begin
            minutes <= '0;
            hours   <= (hours == 5'd23) ? '0 : hours + 5'd1;
          end else begin
            minutes <= minutes + 6'd1;
          end
        end else begin
          seconds <= seconds + 6'd1;
        end
      end else if (bump) begin
        if (state == SET_HR) hours   <= (hours == 5'd23) ? '0 : hours + 5'd1;
        else                 minutes <= (minutes == 6'd59) ? '0 : minutes + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: a seconds-of-day model checked every cycle,
// plus hand-computed snapshots at key points of the setting/run/reset scenarios.
module tb_time_set_controller;

  localparam int unsigned CLK_HZ     = 16;
  localparam int unsigned HOLD_TICKS = 4;
  localparam int unsigned QTR        = CLK_HZ / 4;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: cycles since the tick phase origin, time as seconds of day,
  // mode number, blink level, previous button levels, tick4s seen while holding.
  int unsigned m_cyc  = 0;
  int unsigned m_tod  = 0;
  int unsigned m_mode = 0;
  bit          m_blink = 1'b0;
  bit          m_pm = 1'b0, m_pi = 1'b0;
  int unsigned m_held = 0;
  int unsigned cyc_no = 0;

  time_set_controller #(
    .CLK_HZ    (CLK_HZ),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_step();
    bit t4, t1, me, ie, bump;
    int unsigned old_mode, h, m, s;
    if (reset) begin
      m_cyc = 0; m_tod = 0; m_mode = 0; m_blink = 1'b0; m_held = 0;
      m_pm = btn_mode; m_pi = btn_inc;
      return;
    end
    m_cyc++;
    t4 = (m_cyc % QTR) == 0;
    t1 = (m_cyc % CLK_HZ) == 0;
    me = btn_mode && !m_pm;
    ie = btn_inc && !m_pi;
    old_mode = m_mode;
    bump = 1'b0;
    if (old_mode == 0 && t1) m_tod = (m_tod + 1) % 86400;
    if (old_mode == 0 || !btn_inc || me || ie) begin
      m_held = 0;
      bump = (old_mode != 0) && ie && !me;
    end else if (t4) begin
      if (m_held >= HOLD_TICKS) bump = 1'b1;
      else m_held++;
    end
    if (bump) begin
      h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
      if (old_mode == 1) h = (h + 1) % 24;
      else               m = (m + 1) % 60;
      m_tod = h * 3600 + m * 60 + s;
    end
    if (old_mode != 0 && t4) m_blink = !m_blink;
    if (me) m_mode = (m_mode + 1) % 3;
    if (m_mode == 0) m_blink = 1'b0;
    if (me && old_mode == 2) begin
      m_tod = m_tod - (m_tod % 60);
      m_cyc = 0;
    end
    m_pm = btn_mode;
    m_pi = btn_inc;
  endtask

  task automatic cmp_all();
    logic [19:0] got, exp;
    got = {hours, minutes, seconds, mode, blink};
    exp = {5'(m_tod / 3600), 6'((m_tod / 60) % 60), 6'(m_tod % 60), 2'(m_mode), m_blink};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model_cycle_%0d: got %0d:%0d:%0d mode=%0d blink=%0d, expected %0d:%0d:%0d mode=%0d blink=%0d",
               cyc_no, hours, minutes, seconds, mode, blink,
               m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode, m_blink);
    end
  endtask

  task automatic check_lit(input string name, input int unsigned h, input int unsigned m,
                           input int unsigned s, input int unsigned md, input int unsigned b);
    n_checks++;
    if (hours !== 5'(h) || minutes !== 6'(m) || seconds !== 6'(s) || mode !== 2'(md) || blink !== 1'(b)) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, expected %0d:%0d:%0d mode=%0d blink=%0d",
               name, hours, minutes, seconds, mode, blink, h, m, s, md, b);
    end
  endtask

  // One clock: model advances on the edge, outputs compared just after it, inputs change at negedge.
  task automatic cyc();
    @(posedge clk_in);
    model_step();
    #1;
    cyc_no++;
    cmp_all();
    @(negedge clk_in);
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1; cyc();
    btn_mode = 1'b0; cyc();
  endtask

  task automatic pulse_inc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      btn_inc = 1'b1; cyc();
      btn_inc = 1'b0; cyc();
    end
  endtask

  initial begin
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cycles(2);
    reset = 1'b0;
    check_lit("reset_state", 0, 0, 0, 0, 0);

    cycles(960);
    check_lit("run_one_minute", 0, 1, 0, 0, 0);

    pulse_mode();
    pulse_inc(23);
    check_lit("set_hours_23", 23, 1, 0, 1, 0);
    pulse_mode();
    pulse_inc(58);
    check_lit("set_minutes_59", 23, 59, 0, 2, 1);
    btn_mode = 1'b1; cyc();
    btn_mode = 1'b0;
    check_lit("exit_to_run", 23, 59, 0, 0, 0);
    cycles(959);
    check_lit("before_day_wrap", 23, 59, 59, 0, 0);
    cyc();
    check_lit("day_wrap", 0, 0, 0, 0, 0);

    pulse_mode();
    pulse_inc(12);
    check_lit("hours_mid_12", 12, 0, 0, 1, 0);
    pulse_inc(12);
    check_lit("hours_24_incs", 0, 0, 0, 1, 0);

    btn_mode = 1'b1; btn_inc = 1'b1; cyc();
    btn_mode = 1'b0; btn_inc = 1'b0; cyc();
    check_lit("mode_beats_inc", 0, 0, 0, 2, 1);

    btn_inc = 1'b1; cycles(40);
    btn_inc = 1'b0; cyc();
    check_lit("hold_40_cycles", 0, 7, 0, 2, 1);

    btn_inc = 1'b1; cycles(30);
    check_lit("repeat_before_reset", 0, 11, 0, 2, 0);
    reset = 1'b1; cyc();
    reset = 1'b0;
    check_lit("reset_mid_repeat", 0, 0, 0, 0, 0);
    cycles(40);
    check_lit("held_inc_in_run", 0, 0, 2, 0, 0);
    btn_inc = 1'b0;

    btn_mode = 1'b1; reset = 1'b1; cycles(2);
    reset = 1'b0; cycles(5);
    check_lit("mode_held_through_reset", 0, 0, 0, 0, 0);
    btn_mode = 1'b0; cyc();
    btn_mode = 1'b1; cyc();
    btn_mode = 1'b0;
    check_lit("mode_after_release", 0, 0, 0, 1, 0);
    cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
